irrigacao_multizona: RTL and testbench
======================================

IRRIGACAO_MULTIZONA -- requirements
Module: irrigacao_multizona

Interface
REQ-001 SHALL have parameter N_ZONAS, default 4, number of irrigation zones (2..16).
REQ-002 SHALL have parameter W_TEMPO, default 16, width of the phase timer.
REQ-003 SHALL have parameters T_ASP=100, T_GOT=400, T_AGRO=50, T_LIMP=60 and T_MAX_ENCHER=1000, giving phase durations in clock cycles; each fits in W_TEMPO bits and is at least 1.
REQ-004 SHALL define ZW = $clog2(N_ZONAS), the zone index width.
REQ-005 Port Clock, input, 1 bit: single clock, all state updates on its rising edge.
REQ-006 Port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Ports H, M and L, inputs, 1 bit each: tank level sensors (high, middle, low); 1 means water is at or above that sensor.
REQ-008 Port Us, input, N_ZONAS bits: bit i = 1 means soil in zone i is dry and requests water.
REQ-009 Port Ua, input, 1 bit: 1 means air humidity is adequate.
REQ-010 Port T, input, 1 bit: 1 means high temperature.
REQ-011 Port Ag, input, 1 bit: agrochemical application request.
REQ-012 Outputs Ve (inlet valve), Vs (drain valve), Bs_Ag (agrochemical pump), E (error) and Al (alarm), 1 bit each.
REQ-013 Output Bs, N_ZONAS bits: zone valve/pump enables.
REQ-014 Output Zona, ZW bits: index of the zone being watered, 0 when no zone is active.
REQ-015 Outputs S_Cheio, S_Enchendo, S_Aspersao, S_Gotejamento, S_Agro, S_Limpeza, S_SaidaLimpeza and S_Erro, 1 bit each: one-hot state indicators.

Function
REQ-016 All outputs SHALL be Moore outputs, decoded from registered state only, with no combinational path from any input to any output.
REQ-017 In every state except ERRO, an invalid level combination (H&~M or M&~L) SHALL take the FSM to ERRO on the next edge, with top priority.
REQ-018 CHEIO transitions, in priority order:
  - L=0 -> ENCHENDO
  - agro pending -> AGRO
  - any Us bit = 1 -> watering state
  - otherwise stay in CHEIO
REQ-019 ENCHENDO SHALL drive Ve=1 and SHALL go to CHEIO when H=1.
REQ-020 If ENCHENDO lasts T_MAX_ENCHER cycles without H=1, the FSM SHALL go to ERRO.
REQ-021 Zone selection SHALL be round-robin: the search starts at ptr+1 modulo N_ZONAS, and the first zone with Us=1 is chosen.
REQ-022 ptr SHALL update to the chosen zone only when watering completes (by timeout or early end); an aborted watering leaves ptr unchanged.
REQ-023 Watering mode SHALL be fixed at entry: GOTEJAMENTO if T=1 or Ua=0, otherwise ASPERSAO.
REQ-024 In a watering state, exactly one Bs bit SHALL be 1 (the chosen zone) and Zona SHALL equal its index.
REQ-025 Watering SHALL last exactly T_ASP or T_GOT cycles, then return to CHEIO.
REQ-026 Watering SHALL end early, returning to CHEIO, on the cycle after Us[Zona] reads 0.
REQ-027 If L=0 during watering, the FSM SHALL abort to ENCHENDO.
REQ-028 A rising edge of Ag (Ag registered once) SHALL set agro_pending.
REQ-029 agro_pending SHALL clear on entry to AGRO; an edge during AGRO sets it again.
REQ-030 AGRO SHALL drive Bs_Ag=1 and all Bs bits = 1 for T_AGRO cycles, then go to LIMPEZA.
REQ-031 In AGRO, L=0 SHALL still lead to LIMPEZA early.
REQ-032 LIMPEZA SHALL drive Ve=1 and Vs=1 for T_LIMP cycles, then go to SAIDA_LIMPEZA.
REQ-033 SAIDA_LIMPEZA SHALL drive Vs=1 until L=0, then go to ENCHENDO.
REQ-034 ERRO SHALL drive E=1 and Al=1 with all valves and pumps at 0.
REQ-035 ERRO SHALL go to ENCHENDO after the level combination has been valid for 2 consecutive cycles.
REQ-036 A single timer SHALL load on every state entry; its count SHALL saturate, never wrap.

Reset
REQ-037 When Reset=0, the FSM SHALL be forced to CHEIO immediately.
REQ-038 During reset: ptr=N_ZONAS-1, agro_pending=0, timer=0, Ag register=0.
REQ-039 During reset all outputs SHALL be 0 except S_Cheio=1.
REQ-040 Reset mid-operation SHALL abandon the current phase with no residual valve activity.

Verification (N_ZONAS=4, T_ASP=5, T_GOT=8, T_AGRO=3, T_LIMP=4, T_MAX_ENCHER=20)
REQ-041 HML=000 after reset -> ENCHENDO with Ve=1; raise H,M,L -> CHEIO one edge after H=1.
REQ-042 Tank full, Us=1010, Ua=1, T=0 -> zone 1 in ASPERSAO with Bs=0010 for 5 cycles, then zone 3 with Bs=1000.
REQ-043 Tank full, Us=0001, T=1 -> GOTEJAMENTO for 8 cycles; drop L at cycle 3 -> ENCHENDO; after refill, zone 0 is served again.
REQ-044 Ag pulse while full -> AGRO with Bs_Ag=1 and Bs=1111 for 3 cycles, then LIMPEZA with Ve=Vs=1 for 4 cycles, then SAIDA_LIMPEZA until L=0, then ENCHENDO.
REQ-045 HML=100 -> ERRO with E=Al=1 on the next edge; HML=111 for 2 cycles -> ENCHENDO.
REQ-046 H held at 0 for 20 cycles in ENCHENDO -> ERRO; Reset=0 during ASPERSAO -> S_Cheio=1 and Bs=0000 immediately.

Source files
------------

// File: rtl/irrigacao_multizona.sv
// Multizone irrigation controller: tank level supervision, round-robin
// zone watering, agrochemical dosing with rinse cycle and error recovery.
module irrigacao_multizona #(
  parameter int N_ZONAS      = 4,
  parameter int W_TEMPO      = 16,
  parameter int T_ASP        = 100,
  parameter int T_GOT        = 400,
  parameter int T_AGRO       = 50,
  parameter int T_LIMP       = 60,
  parameter int T_MAX_ENCHER = 1000,
  parameter int ZW           = $clog2(N_ZONAS)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               H,
  input  logic               M,
  input  logic               L,
  input  logic [N_ZONAS-1:0] Us,
  input  logic               Ua,
  input  logic               T,
  input  logic               Ag,
  output logic               Ve,
  output logic               Vs,
  output logic               Bs_Ag,
  output logic               E,
  output logic               Al,
  output logic [N_ZONAS-1:0] Bs,
  output logic [ZW-1:0]      Zona,
  output logic               S_Cheio,
  output logic               S_Enchendo,
  output logic               S_Aspersao,
  output logic               S_Gotejamento,
  output logic               S_Agro,
  output logic               S_Limpeza,
  output logic               S_SaidaLimpeza,
  output logic               S_Erro
);

  typedef enum logic [2:0] {
    CHEIO, ENCHENDO, ASPERSAO, GOTEJAMENTO,
    AGRO, LIMPEZA, SAIDA_LIMPEZA, ERRO
  } state_t;

  localparam logic [W_TEMPO-1:0] TMR_MAX = '1;

  state_t             state, next;
  logic [W_TEMPO-1:0] timer;
  logic [ZW-1:0]      ptr, zona, pick;
  logic               ag_q, pend, ok_q;
  logic               valid, found, rega;

  assign valid = ~((H & ~M) | (M & ~L));
  assign rega  = (state == ASPERSAO) || (state == GOTEJAMENTO);

  // Round-robin search starting one past the last zone served
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= N_ZONAS; k++) begin
      idx = (int'(ptr) + k) % N_ZONAS;
      if (!found && Us[idx]) begin
        found = 1'b1;
        pick  = ZW'(idx);
      end
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      CHEIO: begin
        if (!L)         next = ENCHENDO;
        else if (pend)  next = AGRO;
        else if (found) next = (T || !Ua) ? GOTEJAMENTO : ASPERSAO;
      end
      ENCHENDO: begin
        if (H) next = CHEIO;
        else if (timer == W_TEMPO'(T_MAX_ENCHER - 1)) next = ERRO;
      end
      ASPERSAO: begin
        if (!L) next = ENCHENDO;
        else if (timer == W_TEMPO'(T_ASP - 1) || !Us[zona]) next = CHEIO;
      end
      GOTEJAMENTO: begin
        if (!L) next = ENCHENDO;
        else if (timer == W_TEMPO'(T_GOT - 1) || !Us[zona]) next = CHEIO;
      end
      AGRO: begin
        if (!L || timer == W_TEMPO'(T_AGRO - 1)) next = LIMPEZA;
      end
      LIMPEZA: begin
        if (timer == W_TEMPO'(T_LIMP - 1)) next = SAIDA_LIMPEZA;
      end
      SAIDA_LIMPEZA: begin
        if (!L) next = ENCHENDO;
      end
      ERRO: begin
        if (valid && ok_q) next = ENCHENDO;
      end
      default: next = CHEIO;
    endcase
    if (state != ERRO && !valid) next = ERRO;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= CHEIO;
      timer <= '0;
      ptr   <= ZW'(N_ZONAS - 1);
      zona  <= '0;
      ag_q  <= 1'b0;
      pend  <= 1'b0;
      ok_q  <= 1'b0;
    end else begin
      state <= next;
      ag_q  <= Ag;
      ok_q  <= (state == ERRO) && valid;
      pend  <= ((next == AGRO && state != AGRO) ? 1'b0 : pend) | (Ag & ~ag_q);
      if (next != state)        timer <= '0;
      else if (timer != TMR_MAX) timer <= timer + 1'b1;
      if (state == CHEIO && (next == ASPERSAO || next == GOTEJAMENTO))
        zona <= pick;
      // An abort to ENCHENDO or ERRO keeps the old pointer
      if (rega && next == CHEIO) ptr <= zona;
    end
  end

  always_comb begin
    Ve    = 1'b0;
    Vs    = 1'b0;
    Bs_Ag = 1'b0;
    E     = 1'b0;
    Al    = 1'b0;
    Bs    = '0;
    Zona  = '0;
    unique case (state)
      ENCHENDO:      Ve = 1'b1;
      ASPERSAO, GOTEJAMENTO: begin
        Bs   = N_ZONAS'(1) << zona;
        Zona = zona;
      end
      AGRO: begin
        Bs_Ag = 1'b1;
        Bs    = '1;
      end
      LIMPEZA: begin
        Ve = 1'b1;
        Vs = 1'b1;
      end
      SAIDA_LIMPEZA: Vs = 1'b1;
      ERRO: begin
        E  = 1'b1;
        Al = 1'b1;
      end
      default: ;
    endcase
  end

  assign S_Cheio        = (state == CHEIO);
  assign S_Enchendo     = (state == ENCHENDO);
  assign S_Aspersao     = (state == ASPERSAO);
  assign S_Gotejamento  = (state == GOTEJAMENTO);
  assign S_Agro         = (state == AGRO);
  assign S_Limpeza      = (state == LIMPEZA);
  assign S_SaidaLimpeza = (state == SAIDA_LIMPEZA);
  assign S_Erro         = (state == ERRO);

endmodule

// File: tb/tb_irrigacao_multizona.sv
// Directed bench for irrigacao_multizona with short phase timings.
module tb_irrigacao_multizona;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       H, M, L, Ua, T, Ag;
  logic [3:0] Us;
  logic       Ve, Vs, Bs_Ag, E, Al;
  logic [3:0] Bs;
  logic [1:0] Zona;
  logic       S_Cheio, S_Enchendo, S_Aspersao, S_Gotejamento;
  logic       S_Agro, S_Limpeza, S_SaidaLimpeza, S_Erro;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] CHE = 8'h01, ENC = 8'h02, ASP = 8'h04;
  localparam logic [7:0] GOT = 8'h08, AGR = 8'h10, LIM = 8'h20;
  localparam logic [7:0] SAI = 8'h40, ERR = 8'h80;

  irrigacao_multizona #(
    .N_ZONAS(4), .W_TEMPO(16), .T_ASP(5), .T_GOT(8),
    .T_AGRO(3), .T_LIMP(4), .T_MAX_ENCHER(20)
  ) dut (
    .Clock(Clock), .Reset(Reset), .H(H), .M(M), .L(L),
    .Us(Us), .Ua(Ua), .T(T), .Ag(Ag),
    .Ve(Ve), .Vs(Vs), .Bs_Ag(Bs_Ag), .E(E), .Al(Al),
    .Bs(Bs), .Zona(Zona),
    .S_Cheio(S_Cheio), .S_Enchendo(S_Enchendo),
    .S_Aspersao(S_Aspersao), .S_Gotejamento(S_Gotejamento),
    .S_Agro(S_Agro), .S_Limpeza(S_Limpeza),
    .S_SaidaLimpeza(S_SaidaLimpeza), .S_Erro(S_Erro)
  );

  always #5 Clock = ~Clock;

  wire [7:0] st = {S_Erro, S_SaidaLimpeza, S_Limpeza, S_Agro,
                   S_Gotejamento, S_Aspersao, S_Enchendo, S_Cheio};
  // {Ve,Vs,Bs_Ag,E,Al}
  wire [4:0] vo = {Ve, Vs, Bs_Ag, E, Al};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic lvl(input logic [2:0] hml);
    {H, M, L} = hml;
  endtask

  initial begin
    Reset = 1'b0;
    lvl(3'b000);
    Us = 4'b0000; Ua = 1'b1; T = 1'b0; Ag = 1'b0;
    #2;
    check("rst_state", st, CHE);
    check("rst_out", {vo, Bs, Zona}, 0);
    #10 Reset = 1'b1;

    step();
    check("fill_state", st, ENC);
    check("fill_ve", vo, 5'b10000);
    lvl(3'b111);
    step();
    check("full_state", st, CHE);

    Us = 4'b1010;
    step();
    check("asp1_state", st, ASP);
    check("asp1_bs", Bs, 4'b0010);
    check("asp1_zona", Zona, 1);
    check("asp1_valves", vo, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("asp1_hold", st, ASP);
    end
    step();
    check("asp1_done", st, CHE);
    step();
    check("asp3_state", st, ASP);
    check("asp3_bs", Bs, 4'b1000);
    check("asp3_zona", Zona, 3);
    Us = 4'b0000;
    step();
    check("asp3_early", st, CHE);

    Us = 4'b0001; T = 1'b1;
    step();
    check("got_state", st, GOT);
    check("got_bs", Bs, 4'b0001);
    step();
    step();
    check("got_c3", st, GOT);
    lvl(3'b000);
    step();
    check("got_abort", st, ENC);
    check("got_abort_bs", Bs, 4'b0000);
    lvl(3'b111);
    Us = 4'b0011;
    step();
    check("refill", st, CHE);
    step();
    check("got2_state", st, GOT);
    check("got2_zona", Zona, 0);
    Us = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      step();
      check("got2_hold", st, GOT);
    end
    step();
    check("got2_done", st, CHE);
    Us = 4'b0000; T = 1'b0;

    Ag = 1'b1;
    step();
    check("ag_latch", st, CHE);
    Ag = 1'b0;
    step();
    check("agro_state", st, AGR);
    check("agro_out", {vo, Bs}, {5'b00100, 4'b1111});
    for (int i = 0; i < 2; i++) begin
      step();
      check("agro_hold", st, AGR);
    end
    step();
    check("limp_state", st, LIM);
    check("limp_out", {vo, Bs}, {5'b11000, 4'b0000});
    for (int i = 0; i < 3; i++) begin
      step();
      check("limp_hold", st, LIM);
    end
    step();
    check("sai_state", st, SAI);
    check("sai_out", vo, 5'b01000);
    step();
    check("sai_hold", st, SAI);
    lvl(3'b000);
    step();
    check("sai_exit", st, ENC);
    lvl(3'b111);
    step();
    check("agro_refill", st, CHE);
    step();
    check("agro_cleared", st, CHE);

    lvl(3'b100);
    step();
    check("err_state", st, ERR);
    check("err_out", {vo, Bs}, {5'b00011, 4'b0000});
    lvl(3'b111);
    step();
    check("err_hold", st, ERR);
    step();
    check("err_exit", st, ENC);
    step();
    check("err_full", st, CHE);

    lvl(3'b000);
    step();
    check("tmo_enter", st, ENC);
    for (int i = 0; i < 19; i++) begin
      step();
      check("tmo_hold", st, ENC);
    end
    step();
    check("tmo_err", st, ERR);
    lvl(3'b111);
    step();
    step();
    check("tmo_recover", st, ENC);
    step();
    check("tmo_full", st, CHE);

    Us = 4'b0001;
    step();
    check("rst_asp", st, ASP);
    #2 Reset = 1'b0;
    #1;
    check("midrst_state", st, CHE);
    check("midrst_out", {vo, Bs, Zona}, 0);
    #5 Reset = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
